count_capture_fifo: RTL and testbench

Downstream consumer of the free-running counter's count bus. An external event pin (a user GPIO input) timestamps events: each rising edge captures the current count value into a small FIFO. Firmware drains the FIFO through a valid/ready read handshake matching the counter's Wishbone-side protocol. An interrupt line (a candidate for the user irq[0]) flags pending captures and overflow.

---
 rtl/count_capture_fifo.sv | 122 ++++++++++++
 tb/tb_count_capture_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - timestamps capture_in rising edges into a FIFO drained by a valid/ready read
module count_capture_fifo #(
    parameter int BITS        = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BITS-1:0]          count,
    input  logic                     capture_in,
    input  logic                     valid,
    input  logic                     clear_ovf,
    output logic                     ready,
    output logic [BITS-1:0]          rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     overflow,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    prev;
    logic                    s_sync;
    logic                    cap_evt;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [BITS-1:0]         mem [DEPTH];
    logic                    full;
    logic                    do_pop;
    logic                    push_ok;
    logic                    drop;
    logic                    ready_nxt;
    logic [BITS-1:0]         rdata_nxt;

    assign s_sync  = sync_q[SYNC_STAGES-1];
    assign cap_evt = s_sync & ~prev;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign irq     = ~empty | overflow;

    // A pop in the same cycle frees the slot, so a capture into a full FIFO is kept.
    assign push_ok = cap_evt & (~full | do_pop);
    assign drop    = cap_evt & full & ~do_pop;

    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        rdata_nxt = rdata;
        do_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (valid && !ready) begin
                    ready_nxt = 1'b1;
                    state_nxt = ACK;
                    if (!empty) begin
                        rdata_nxt = mem[rd_ptr];
                        do_pop    = 1'b1;
                    end else begin
                        rdata_nxt = '0;
                    end
                end
            end
            ACK: begin
                ready_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sync_q   <= '0;
            prev     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready    <= 1'b0;
            rdata    <= '0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            sync_q <= {sync_q[SYNC_STAGES-2:0], capture_in};
            prev   <= s_sync;
            ready  <= ready_nxt;
            rdata  <= rdata_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A drop on the same edge as clear_ovf keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= count;
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb/tb_count_capture_fifo.sv - scoreboard bench for count_capture_fifo
module tb_count_capture_fifo;

    localparam int BITS  = 16;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [BITS-1:0]       count;
    logic                  capture_in;
    logic                  valid;
    logic                  clear_ovf;
    logic                  ready;
    logic [BITS-1:0]       rdata;
    logic [$clog2(DEPTH):0] level;
    logic                  empty;
    logic                  overflow;
    logic                  irq;

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] exp_q[$];
    logic            model_ovf;

    count_capture_fifo #(.BITS(BITS), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .count(count), .capture_in(capture_in),
        .valid(valid), .clear_ovf(clear_ovf), .ready(ready), .rdata(rdata),
        .level(level), .empty(empty), .overflow(overflow), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after each edge; count models the free-running counter.
    task automatic step();
        @(posedge clk);
        #1;
        count = count + 16'd1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
        check({tag, "_irq"}, 32'(irq), 32'((exp_q.size() != 0) || model_ovf));
    endtask

    // The push lands on the third edge after the rise, sampling count two ticks ahead.
    task automatic capture();
        logic [BITS-1:0] ts;
        ts = count + 16'd2;
        if (exp_q.size() < DEPTH) exp_q.push_back(ts);
        else model_ovf = 1'b1;
        capture_in = 1'b1;
        step(); step(); step();
        capture_in = 1'b0;
        step(); step(); step();
    endtask

    task automatic read(input string tag);
        logic [BITS-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_rdata"}, 32'(rdata), 32'(e));
        step();
        check({tag, "_ready_drop"}, 32'(ready), 32'd0);
        check({tag, "_rdata_hold"}, 32'(rdata), 32'(e));
    endtask

    initial begin
        logic [BITS-1:0] ts;
        logic [BITS-1:0] e;
        reset = 1'b1; count = '0; capture_in = 1'b0; valid = 1'b0; clear_ovf = 1'b0;
        model_ovf = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check_state("rst");

        // Read while empty returns zero
        read("empty_rd");
        check_state("empty_rd");

        // Single capture with a ramping count
        count = 16'h0010;
        capture();
        check_state("cap1");
        read("cap1_rd");
        check_state("cap1_after");

        // Overflow: five captures into four slots
        for (int i = 0; i < 5; i++) capture();
        check_state("ovf_fill");
        // Clear and drop on the same edge: the drop wins
        capture_in = 1'b1;
        step(); step();
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        capture_in = 1'b0;
        step(); step(); step();
        check_state("ovf_clr_race");
        for (int i = 0; i < 4; i++) read("ovf_rd");
        read("ovf_rd5");
        check_state("ovf_drained");
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        model_ovf = 1'b0;
        check_state("ovf_cleared");

        // Full FIFO: capture and pop on the same edge
        for (int i = 0; i < 4; i++) capture();
        check_state("sim_full");
        ts = count + 16'd2;
        e = exp_q.pop_front();
        exp_q.push_back(ts);
        capture_in = 1'b1;
        step(); step();
        valid = 1'b1;
        step();
        valid = 1'b0;
        capture_in = 1'b0;
        check("sim_ready", 32'(ready), 32'd1);
        check("sim_rdata", 32'(rdata), 32'(e));
        check_state("sim_edge");
        step(); step(); step();
        check_state("sim_after");
        for (int i = 0; i < 4; i++) read("sim_rd");
        check_state("sim_drained");

        // valid held high: one pop every two cycles
        for (int i = 0; i < 4; i++) capture();
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) e = exp_q.pop_front();
            step();
            check("hold_ready", 32'(ready), 32'(i % 2 == 0));
            check("hold_rdata", 32'(rdata), 32'(e));
        end
        valid = 1'b0;
        step();
        check_state("hold_end");
        read("hold_rd");

        // Reset with three entries and a read in ACK
        for (int i = 0; i < 5; i++) capture();
        read("rst6_pre");
        check_state("rst6_pre");
        valid = 1'b1;
        void'(exp_q.pop_front());
        step();
        valid = 1'b0;
        check("rst6_ack", 32'(ready), 32'd1);
        reset = 1'b1;
        capture_in = 1'b1;
        step();
        exp_q.delete();
        model_ovf = 1'b0;
        check("rst6_ready", 32'(ready), 32'd0);
        check("rst6_rdata", 32'(rdata), 32'd0);
        check_state("rst6");
        step();
        reset = 1'b0;
        ts = count + 16'd2;
        exp_q.push_back(ts);
        for (int i = 0; i < 6; i++) step();
        check_state("rst6_one_push");
        capture_in = 1'b0;
        step(); step(); step();
        read("rst6_rd");
        read("rst6_rd_empty");
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
